// File: rtl/bcd_to_bin_serial.sv
// Serial packed-BCD to binary converter: one digit per clock, most-significant first,
// acc = acc*10 + digit, with a start/busy/done handshake and a non-decimal digit flag.
module bcd_to_bin_serial #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = $clog2(10**DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);

  localparam int SH_W  = 4 * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SH_W-1:0]    shreg_q, shreg_d;
  logic [BIN_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_flag_q, err_flag_d;
  logic [BIN_W-1:0]   bin_out_q, bin_out_d;
  logic               err_q, err_d;

  logic [3:0]         digit;
  logic [BIN_W-1:0]   acc_next;
  logic               err_next;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    err_flag_d = err_flag_q;
    bin_out_d  = bin_out_q;
    err_d      = err_q;

    // x10 as x8 + x2; an invalid digit may wrap acc, but that result is discarded
    digit    = shreg_q[SH_W-1 -: 4];
    acc_next = (acc_q << 3) + (acc_q << 1) + BIN_W'(digit);
    err_next = err_flag_q | (digit > 4'd9);

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          shreg_d    = bcd_in;
          acc_d      = '0;
          cnt_d      = '0;
          err_flag_d = 1'b0;
          state_d    = S_CONV;
        end
      end
      S_CONV: begin
        shreg_d    = shreg_q << 4;
        acc_d      = acc_next;
        err_flag_d = err_next;
        cnt_d      = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DIGITS - 1)) begin
          state_d   = S_DONE;
          bin_out_d = err_next ? '0 : acc_next;
          err_d     = err_next;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      err_flag_q <= 1'b0;
      bin_out_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      err_flag_q <= err_flag_d;
      bin_out_q  <= bin_out_d;
      err_q      <= err_d;
    end
  end

  // Outputs are pure decodes of registered state
  assign busy    = (state_q == S_CONV);
  assign done    = (state_q == S_DONE);
  assign bin_out = bin_out_q;
  assign err     = err_q;

endmodule

// File: tb/tb_bcd_to_bin_serial.sv
// Bench for bcd_to_bin_serial: a DIGITS=2 and a DIGITS=3 instance checked against a
// decimal-arithmetic reference model through an expected-value queue.
module tb_bcd_to_bin_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start2, start3;
  logic [7:0]  bcd2;
  logic [11:0] bcd3;
  logic        busy2, done2, err2;
  logic        busy3, done3, err3;
  logic [6:0]  bin2;
  logic [9:0]  bin3;

  int checks   = 0;
  int failures = 0;
  logic [10:0] exp_q[$];   // {err, value}

  bcd_to_bin_serial #(.DIGITS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .bcd_in(bcd2),
    .busy(busy2), .done(done2), .bin_out(bin2), .err(err2)
  );

  bcd_to_bin_serial #(.DIGITS(3), .BIN_W(10)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .bcd_in(bcd3),
    .busy(busy3), .done(done3), .bin_out(bin3), .err(err3)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference: positional decimal value, zero with err set if any nibble exceeds 9
  function automatic logic [10:0] ref_model(input logic [15:0] bcd, input int ndig);
    int v;
    int d;
    logic e;
    v = 0;
    e = 1'b0;
    for (int i = 0; i < ndig; i++) begin
      d = int'((bcd >> (4 * i)) & 16'hF);
      if (d > 9) e = 1'b1;
      v += d * (10 ** i);
    end
    if (e) v = 0;
    return {e, 10'(v)};
  endfunction

  function automatic logic [15:0] rand_bcd(input int ndig, input bit valid);
    logic [15:0] b;
    b = '0;
    for (int i = 0; i < ndig; i++)
      b[4*i +: 4] = 4'($urandom_range(valid ? 9 : 15, 0));
    return b;
  endfunction

  // driver: waits up to 20 cycles for done, reporting cycle count and handshake misbehaviour
  task automatic wait_done(input bit sel3, input bit release_start, output int cyc,
                           output logic [9:0] bin, output logic e, output bit bad,
                           output bit timed_out);
    logic d, b;
    cyc = 0; bin = '0; e = 1'b0; bad = 1'b0; timed_out = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1 && release_start) begin
        start2 = 1'b0;
        start3 = 1'b0;
      end
      d = sel3 ? done3 : done2;
      b = sel3 ? busy3 : busy2;
      if (d && b) bad = 1'b1;
      if (!d && !b) bad = 1'b1;
      if (d) begin
        cyc = k;
        bin = sel3 ? bin3 : {3'b000, bin2};
        e   = sel3 ? err3 : err2;
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic convert(input bit sel3, input logic [15:0] bcd, output int cyc,
                         output logic [9:0] bin, output logic e, output bit bad,
                         output bit timed_out);
    if (sel3) begin start3 = 1'b1; bcd3 = bcd[11:0]; end
    else      begin start2 = 1'b1; bcd2 = bcd[7:0];  end
    wait_done(sel3, 1'b1, cyc, bin, e, bad, timed_out);
  endtask

  // one conversion scored against the model, latency included
  task automatic run_one(input string name, input bit sel3, input logic [15:0] bcd);
    int cyc; logic [9:0] bin; logic e; bit bad, to; logic [10:0] exp;
    int ndig;
    ndig = sel3 ? 3 : 2;
    exp_q.push_back(ref_model(bcd, ndig));
    convert(sel3, bcd, cyc, bin, e, bad, to);
    exp = exp_q.pop_front();
    checks++;
    if (to || cyc !== ndig + 1 || bad) begin
      failures++;
      $display("FAIL %s latency bcd=%h: got cyc=%0d timeout=%0b badhs=%0b, need cyc=%0d",
               name, bcd, cyc, to, bad, ndig + 1);
    end
    checks++;
    if (bin !== exp[9:0]) begin
      failures++;
      $display("FAIL %s bin_out bcd=%h: got %0d, need %0d", name, bcd, bin, exp[9:0]);
    end
    checks++;
    if (e !== exp[10]) begin
      failures++;
      $display("FAIL %s err bcd=%h: got %0b, need %0b", name, bcd, e, exp[10]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start2 = 1'b1; start3 = 1'b1; bcd2 = 8'h99; bcd3 = 12'h999;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy2, done2, err2} !== 3'b000 || bin2 !== 7'd0) begin
      failures++;
      $display("FAIL reset_dut2 got busy=%0b done=%0b bin=%0d err=%0b, need all 0",
               busy2, done2, bin2, err2);
    end
    checks++;
    if ({busy3, done3, err3} !== 3'b000 || bin3 !== 10'd0) begin
      failures++;
      $display("FAIL reset_dut3 got busy=%0b done=%0b bin=%0d err=%0b, need all 0",
               busy3, done3, bin3, err3);
    end
    rst_n = 1'b1; start2 = 1'b0; start3 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (busy2 !== 1'b0 || done2 !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle got busy=%0b done=%0b, need 0 0", busy2, done2);
      end
    end
  endtask

  task automatic test_sweep();
    for (int t = 0; t < 10; t++)
      for (int o = 0; o < 10; o++)
        run_one("sweep2", 1'b0, 16'((t << 4) | o));
    repeat (30) run_one("rand2", 1'b0, rand_bcd(2, 1'b0));
  endtask

  task automatic test_invalid();
    run_one("invalid_4A", 1'b0, 16'h004A);
    checks++;
    @(negedge clk);
    if (done2 !== 1'b0 || bin2 !== 7'd0 || err2 !== 1'b1) begin
      failures++;
      $display("FAIL invalid_hold got done=%0b bin=%0d err=%0b, need 0 0 1", done2, bin2, err2);
    end
    run_one("after_invalid_37", 1'b0, 16'h0037);
  endtask

  task automatic test_handshake();
    int cyc; logic [9:0] bin; logic e; bit bad, to;
    start2 = 1'b1; bcd2 = 8'h21;
    @(negedge clk);                         // cycle 1
    checks++;
    if (busy2 !== 1'b1 || done2 !== 1'b0) begin
      failures++;
      $display("FAIL hs_cycle1 got busy=%0b done=%0b, need 1 0", busy2, done2);
    end
    start2 = 1'b1; bcd2 = 8'h55;
    @(negedge clk);                         // cycle 2
    checks++;
    if (busy2 !== 1'b1 || done2 !== 1'b0) begin
      failures++;
      $display("FAIL hs_cycle2 got busy=%0b done=%0b, need 1 0", busy2, done2);
    end
    start2 = 1'b1; bcd2 = 8'h66;
    @(negedge clk);                         // cycle 3
    checks++;
    if (done2 !== 1'b1 || busy2 !== 1'b0 || bin2 !== 7'd21 || err2 !== 1'b0) begin
      failures++;
      $display("FAIL hs_ignored_start got done=%0b busy=%0b bin=%0d err=%0b, need 1 0 21 0",
               done2, busy2, bin2, err2);
    end
    // start in the DONE cycle begins the next conversion
    bcd2 = 8'h78;
    wait_done(1'b0, 1'b1, cyc, bin, e, bad, to);
    checks++;
    if (to || cyc !== 3 || bad || bin !== 10'd78 || e !== 1'b0) begin
      failures++;
      $display("FAIL hs_from_done got cyc=%0d to=%0b bad=%0b bin=%0d err=%0b, need 3 0 0 78 0",
               cyc, to, bad, bin, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v[3];
    logic [10:0] exp;
    bit exp_done;
    for (int i = 0; i < 3; i++) v[i] = rand_bcd(2, ($urandom_range(3, 0) != 0));
    start2 = 1'b1; bcd2 = v[0][7:0];
    for (int i = 0; i < 3; i++) exp_q.push_back(ref_model(v[i], 2));
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      exp_done = (k % 3 == 0);
      checks++;
      if (done2 !== exp_done || busy2 !== !exp_done) begin
        failures++;
        $display("FAIL b2b_timing cycle=%0d got done=%0b busy=%0b, need done=%0b",
                 k, done2, busy2, exp_done);
      end
      if (exp_done) begin
        exp = exp_q.pop_front();
        checks++;
        if (bin2 !== exp[6:0] || err2 !== exp[10]) begin
          failures++;
          $display("FAIL b2b_result cycle=%0d got bin=%0d err=%0b, need bin=%0d err=%0b",
                   k, bin2, err2, exp[6:0], exp[10]);
        end
        if (k < 9) bcd2 = v[k / 3][7:0];
        else       start2 = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    start2 = 1'b1; bcd2 = 8'h88;
    @(negedge clk);                         // cycle 1
    start2 = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    checks++;
    if (busy2 !== 1'b0 || done2 !== 1'b0 || bin2 !== 7'd0 || err2 !== 1'b0) begin
      failures++;
      $display("FAIL midreset_state got busy=%0b done=%0b bin=%0d err=%0b, need 0 0 0 0",
               busy2, done2, bin2, err2);
    end
    repeat (5) begin
      @(negedge clk);
      if (done2) saw_done = 1'b1;
    end
    checks++;
    if (saw_done || bin2 !== 7'd0) begin
      failures++;
      $display("FAIL midreset_no_done got saw_done=%0b bin=%0d, need 0 0", saw_done, bin2);
    end
    run_one("after_reset_42", 1'b0, 16'h0042);
  endtask

  task automatic test_digits3();
    run_one("d3_999", 1'b1, 16'h0999);
    run_one("d3_255", 1'b1, 16'h0255);
    run_one("d3_000", 1'b1, 16'h0000);
    run_one("d3_invalid", 1'b1, 16'h09F1);
    repeat (20) run_one("d3_rand_valid", 1'b1, rand_bcd(3, 1'b1));
    repeat (10) run_one("d3_rand_any", 1'b1, rand_bcd(3, 1'b0));
  endtask

  initial begin
    rst_n = 1'b0; start2 = 1'b0; start3 = 1'b0; bcd2 = '0; bcd3 = '0;
    test_reset();
    test_sweep();
    test_invalid();
    test_handshake();
    @(negedge clk);
    test_back_to_back();
    @(negedge clk);
    test_reset_mid();
    test_digits3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin_serial.md
# bcd_to_bin_serial

Sequential packed-BCD to binary converter. It is the inverse of the lab's binary-to-BCD digit decoder and turns switch- or keypad-entered decimal digits back into a binary value for the ALU and counter datapaths. It processes one BCD digit per clock, most-significant digit first, using acc = acc*10 + digit. It uses a start/busy/done handshake and flags non-decimal digit codes.

## Interface
- DIGITS, default 2: number of 4-bit BCD digits in the input, 1..4.
- BIN_W, default $clog2(10**DIGITS): output width. This is 7 for DIGITS=2 and 10 for DIGITS=3.
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  in  1  request a conversion. Accepted only in IDLE or DONE.
- bcd_in  in  4*DIGITS  packed BCD. Digit i occupies bits [4i+3:4i], and digit DIGITS-1 is the most significant. Sampled only on the accepting edge.
- busy  out  1  high while in CONV.
- done  out  1  one-cycle pulse; bin_out and err are valid and updated in this cycle.
- bin_out  out  BIN_W  converted result, held until the next done.
- err  out  1  at least one digit of the last conversion was greater than 9. Held with bin_out.

## Operation
- FSM states:
  - IDLE: busy=0, done=0.
  - CONV: busy=1.
  - DONE: done=1, busy=0.
- IDLE:
  - If start=1 on an edge: capture bcd_in into a shift register, clear acc and the digit counter, clear the internal error flag, and go to CONV.
  - Otherwise stay in IDLE.
- CONV, once per cycle:
  - Take the top nibble d of the shift register, then shift the register left by 4.
  - Update acc <= (acc<<3) + (acc<<1) + d. The multiply by 10 is built from shifts and adds; no multiplier is inferred.
  - If d > 9, set the internal error flag. The update still happens, but the result is discarded at the end.
  - When the counter reaches DIGITS-1, go to DONE on that same edge.
- On the CONV→DONE edge:
  - bin_out <= error ? 0 : final acc.
  - err <= error.
- DONE:
  - If start=1: accept a new conversion exactly as in IDLE and go to CONV (back-to-back).
  - Otherwise go to IDLE.
- start while in CONV is ignored and has no side effects. bcd_in is don't-care except on the accepting edge.
- Width rule: the largest intermediate value is 10^DIGITS-1, which fits in BIN_W. acc is BIN_W wide and never overflows.
- Reset, on any edge with rst_n=0 and in any state:
  - state=IDLE, busy=0, done=0, bin_out=0, err=0, acc=0.
  - Any conversion in progress is abandoned with no done pulse.

## Timing
- Let cycle 0 be the cycle with start=1 sampled in IDLE or DONE.
- Cycles 1..DIGITS: busy=1.
- Cycle DIGITS+1: done=1, with the new bin_out and err visible.
- Latency from the start edge to done is DIGITS+1 cycles, which is 3 for the default configuration.
- Throughput with start held high is one result every DIGITS+1 cycles.
- done is never high for two consecutive cycles.
- busy and done are never high at the same time.
- bin_out and err change only on the edge entering DONE, or on reset.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with start=1 → busy=0, done=0, bin_out=0, err=0. Release reset with start=0 → stays in IDLE.
- DIGITS=2 sweep: for every bcd_in from 0x00 to 0x99 with valid digits, pulse start → done exactly 3 cycles later with bin_out equal to the decimal value (e.g. 0x99→99/0x63, 0x15→15, 0x00→0) and err=0.
- Invalid digit: bcd_in=0x4A → done at cycle 3 with bin_out=0, err=1. Then bcd_in=0x37 → bin_out=37, err=0.
- Handshake: start again at cycles 1 and 2 during CONV with a different bcd_in → ignored. Exactly one done, carrying the original result. Then start asserted in the DONE cycle → a second done 3 cycles later.
- Reset mid-operation: start with 0x88, drive rst_n=0 at cycle 1 → no done pulse, bin_out=0. After release, converting 0x42 → 42.
- DIGITS=3, BIN_W=10: bcd_in=0x999 → done at cycle 4 with bin_out=999. bcd_in=0x255 → bin_out=255.
